axi_lite_rr_arbiter: RTL

- N-master to 1-slave AXI4-Lite arbiter. It replaces the fixed-priority two-master arbiter between the IFU/LSU (and future DMA/debug masters) and the shared memory/xbar port.
- Read and write paths are arbitrated independently, each with a round-robin grant. Each path allows one outstanding transaction.
- Grants are registered, so W data is only accepted from the master that owns the write grant.

---
 rtl/axi_lite_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_lite_rr_arbiter
// Purpose  : N-master to 1-slave AXI4-Lite arbiter. The read and write paths
//            are arbitrated independently, each with a registered round-robin
//            grant. Each path allows one outstanding transaction.
// Ports    : clk, reset           - clock, async active-high reset
//            m_ar*/m_r*           - per-master read channels (R data broadcast)
//            m_aw*/m_w*/m_b*      - per-master write channels (B resp broadcast)
//            s_*                  - single slave-side AXI4-Lite port
//            rd_grant/wr_grant    - current or last granted master per path
//            rd_busy/wr_busy      - path has a transaction in flight
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  localparam int IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          reset,
  // master read side
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MASTERS-1:0]        m_arvalid,
  output logic [NUM_MASTERS-1:0]        m_arready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [1:0]                    m_rresp,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  input  logic [NUM_MASTERS-1:0]        m_rready,
  // master write side
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr,
  input  logic [NUM_MASTERS-1:0]        m_awvalid,
  output logic [NUM_MASTERS-1:0]        m_awready,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*STRB_W-1:0] m_wmask,
  input  logic [NUM_MASTERS-1:0]        m_wvalid,
  output logic [NUM_MASTERS-1:0]        m_wready,
  output logic [1:0]                    m_bresp,
  output logic [NUM_MASTERS-1:0]        m_bvalid,
  input  logic [NUM_MASTERS-1:0]        m_bready,
  // slave side
  output logic [ADDR_W-1:0]             s_araddr,
  output logic                          s_arvalid,
  input  logic                          s_arready,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic [1:0]                    s_rresp,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  output logic [ADDR_W-1:0]             s_awaddr,
  output logic                          s_awvalid,
  input  logic                          s_awready,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [STRB_W-1:0]             s_wmask,
  output logic                          s_wvalid,
  input  logic                          s_wready,
  input  logic [1:0]                    s_bresp,
  input  logic                          s_bvalid,
  output logic                          s_bready,
  // status
  output logic [IDX_W-1:0]              rd_grant,
  output logic [IDX_W-1:0]              wr_grant,
  output logic                          rd_busy,
  output logic                          wr_busy
);

  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam int PW = IDX_W + 1;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_REQ  = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  rd_state_t              rd_state;
  wr_state_t              wr_state;
  logic [IDX_W-1:0]       rd_ptr;
  logic [IDX_W-1:0]       wr_ptr;
  logic                   aw_done;
  logic                   w_done;
  logic [IDX_W-1:0]       rd_win;
  logic [IDX_W-1:0]       wr_win;
  logic [NUM_MASTERS-1:0] rd_sel;
  logic [NUM_MASTERS-1:0] wr_sel;
  logic                   aw_hs;
  logic                   w_hs;

  // First requester at or after ptr, wrapping modulo NUM_MASTERS.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                               input logic [IDX_W-1:0]       ptr);
    logic [IDX_W-1:0] win;
    logic [PW-1:0]    sum;
    logic [IDX_W-1:0] idx;
    logic             found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sum = {1'b0, ptr} + PW'(i);
      if (sum >= PW'(NUM_MASTERS)) begin
        sum = sum - PW'(NUM_MASTERS);
      end
      idx = sum[IDX_W-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return win;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
    return (k == IDX_W'(NUM_MASTERS - 1)) ? '0 : k + 1'b1;
  endfunction

  assign rd_win = rr_pick(m_arvalid, rd_ptr);
  assign wr_win = rr_pick(m_awvalid, wr_ptr);
  assign rd_sel = NUM_MASTERS'(1) << rd_grant;
  assign wr_sel = NUM_MASTERS'(1) << wr_grant;

  assign rd_busy = (rd_state != RD_IDLE);
  assign wr_busy = (wr_state != WR_IDLE);

  // ---------------------------------------------------------------- read path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      rd_ptr   <= '0;
      rd_grant <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (|m_arvalid) begin
            rd_grant <= rd_win;
            rd_ptr   <= next_idx(rd_win);
            rd_state <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (s_arvalid && s_arready) begin
            rd_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (s_rvalid && s_rready) begin
            rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // The slave address bus always shows the granted slice (master 0 after
  // reset); only the valid/ready strobes depend on the state.
  assign s_araddr = m_araddr[rd_grant*ADDR_W +: ADDR_W];
  assign m_rdata  = s_rdata;
  assign m_rresp  = s_rresp;

  always_comb begin
    s_arvalid = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    s_rready  = 1'b0;
    case (rd_state)
      RD_ADDR: begin
        s_arvalid = m_arvalid[rd_grant];
        if (s_arready) begin
          m_arready = rd_sel;
        end
      end
      RD_DATA: begin
        if (s_rvalid) begin
          m_rvalid = rd_sel;
        end
        s_rready = m_rready[rd_grant];
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------- write path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state <= WR_IDLE;
      wr_ptr   <= '0;
      wr_grant <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (|m_awvalid) begin
            wr_grant <= wr_win;
            wr_ptr   <= next_idx(wr_win);
            wr_state <= WR_REQ;
          end
        end
        WR_REQ: begin
          // A handshake in this cycle counts toward completion.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            wr_state <= WR_RESP;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (s_bvalid && s_bready) begin
            wr_state <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  assign s_awaddr = m_awaddr[wr_grant*ADDR_W +: ADDR_W];
  assign s_wdata  = m_wdata[wr_grant*DATA_W +: DATA_W];
  assign s_wmask  = m_wmask[wr_grant*STRB_W +: STRB_W];
  assign m_bresp  = s_bresp;
  assign aw_hs    = s_awvalid && s_awready;
  assign w_hs     = s_wvalid && s_wready;

  always_comb begin
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    s_bready  = 1'b0;
    case (wr_state)
      WR_REQ: begin
        // A completed channel is silenced so it never handshakes twice.
        s_awvalid = m_awvalid[wr_grant] && !aw_done;
        s_wvalid  = m_wvalid[wr_grant] && !w_done;
        if (s_awready && !aw_done) begin
          m_awready = wr_sel;
        end
        if (s_wready && !w_done) begin
          m_wready = wr_sel;
        end
      end
      WR_RESP: begin
        if (s_bvalid) begin
          m_bvalid = wr_sel;
        end
        s_bready = m_bready[wr_grant];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
